// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared format codes, opcodes and beat layout for the immediate generator
package imm_gen_pkg;
  typedef enum logic [2:0] {
    SEL_ZERO = 3'b000,
    SEL_IZ   = 3'b001,
    SEL_IS   = 3'b010,
    SEL_S    = 3'b011,
    SEL_B    = 3'b100,
    SEL_U    = 3'b101,
    SEL_J    = 3'b110,
    SEL_AUTO = 3'b111
  } imm_sel_e;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] STORE   = 7'b0100011;
  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] OP      = 7'b0110011;
  localparam logic [6:0] CUSTOM0 = 7'b0001011;
  localparam int XLEN_MAX = 64;
  localparam int TAG_MAX  = 16;
  // Sized for the widest build; narrower instances use the low bits only.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic [2:0]          fmt;
    logic [TAG_MAX-1:0]  tag;
    logic                err;
  } imm_beat_t;
endpackage

// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready instruction-in and immediate-out bus of the immediate generator
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  modport master (
    output in_valid, in_instr, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_err
  );
  modport slave (
    input  in_valid, in_instr, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_comb.sv
// imm_gen_comb: opcode resolve and immediate extend; IMM_GEN_GEMM_EN adds the custom-0 GEMM format
module imm_gen_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      sel_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            err_o
);
  imm_sel_e fmt;
  always_comb begin
    fmt   = imm_sel_e'(sel_i);
    err_o = 1'b0;
    if (sel_i == SEL_AUTO) begin
      case (instr_i[6:0])
        OP_IMM, LOAD, JALR: fmt = SEL_IS;
        STORE:              fmt = SEL_S;
        BRANCH:             fmt = SEL_B;
        LUI, AUIPC:         fmt = SEL_U;
        JAL:                fmt = SEL_J;
        OP:                 fmt = SEL_ZERO;
`ifdef IMM_GEN_GEMM_EN
        CUSTOM0:            fmt = SEL_AUTO;
`endif
        default: begin
          fmt   = SEL_ZERO;
          err_o = 1'b1;
        end
      endcase
    end
  end
  // After resolve, SEL_AUTO can only mean the GEMM format.
  always_comb
    imm_o = fmt == SEL_IZ ? XLEN'(instr_i[31:20]) :
            fmt == SEL_IS ? XLEN'($signed(instr_i[31:20])) :
            fmt == SEL_S  ? XLEN'($signed({instr_i[31:25], instr_i[11:7]})) :
            fmt == SEL_B  ? XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0})) :
            fmt == SEL_U  ? XLEN'($signed({instr_i[31:12], 12'b0})) :
            fmt == SEL_J  ? XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0})) :
            fmt == SEL_AUTO ? XLEN'(instr_i[31:17]) : '0;
  assign fmt_o = fmt;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a one-entry skid buffer behind the head register
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic     clk,
  input logic     rst,
  imm_gen_if.slave bus
);
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            err;
  imm_beat_t       new_beat, head_q, head_d, skid_q, skid_d;
  logic            head_v_q, head_v_d, skid_v_q, skid_v_d, rdy_q;
  logic            acc, drain;
  imm_gen_comb #(.XLEN(XLEN)) u_comb (
    .instr_i (bus.in_instr),
    .sel_i   (bus.in_sel),
    .imm_o   (imm),
    .fmt_o   (fmt),
    .err_o   (err)
  );
  always_comb begin
    new_beat = '{imm: XLEN_MAX'(imm), fmt: fmt, tag: TAG_MAX'(bus.in_tag), err: err};
    acc      = bus.in_valid && rdy_q;
    drain    = head_v_q && bus.out_ready;
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      if (drain) begin
        head_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (acc && (!head_v_q || drain)) begin
      head_d   = new_beat;
      head_v_d = 1'b1;
    end else if (acc) begin
      skid_d   = new_beat;
      skid_v_d = 1'b1;
    end else if (drain) begin
      head_v_d = 1'b0;
    end
  end
  // in_ready follows skid occupancy only, so it never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
    end
  end
  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = head_v_q;
  assign bus.out_imm   = head_q.imm[XLEN-1:0];
  assign bus.out_fmt   = head_q.fmt;
  assign bus.out_tag   = head_q.tag[TAG_W-1:0];
  assign bus.out_err   = head_q.err;
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator that replaces the single-cycle combinational extender in the core datapath. It adds XLEN generalisation (RV32/RV64), an opcode-driven auto-decode mode, valid/ready handshaking with a registered output and a one-entry skid buffer, a tag passthrough, and an illegal-format flag. It sits between the decode stage and the ALU operand mux.

## Interface
Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each instruction (e.g. rd/ROB index).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high. One clock domain only.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_sel  in  3  format select: 000 zero, 001 I zero-ext, 010 I sign-ext, 011 S, 100 B, 101 U, 110 J, 111 auto-decode from opcode.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  resolved format code, same encoding as in_sel; 111 means GEMM format.
- out_tag  out  TAG_W  tag of the beat.
- out_err  out  1  auto-decode found an unsupported opcode.

## Operation
- Transfer on the input side when in_valid && in_ready; on the output side when out_valid && out_ready.
- Explicit sel codes 000–110:
  - I, S and B immediates are sign-extended to XLEN from bit 11 (I, S) or bit 12 (B). B and J have bit 0 = 0.
  - 001 zero-extends inst[31:20].
  - U is {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J is sign-extended from imm bit 20.
- in_sel = 111 resolves the format from inst[6:0]:
  - 0010011, 0000011, 1100111 → I sign-ext.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → zero.
  - Any other opcode → zero, out_err=1.
- out_err is always 0 for explicit select codes.
- out_fmt always reports the resolved format, never 111 from an auto-decode miss.

## Timing
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=000, out_tag=0, out_err=0. The skid entry is marked empty.
- Latency: 1 cycle from input accept to out_valid. Throughput is 1 per cycle while out_ready=1.
- Output register holds the head beat. While out_valid && !out_ready, out_imm, out_fmt, out_tag and out_err must not change.
- Skid buffer (1 entry): an input accepted while the head is stalled goes into the skid. in_ready is registered and is 0 whenever the skid is full.
- When the head drains and the skid is full, the skid moves to the head on the same edge, and in_ready returns to 1 the next cycle.
- Simultaneous drain and accept with the skid empty: the new beat goes directly to the head, with no bubble.
- in_ready never depends combinationally on out_ready.
- rst asserted mid-stream drops both entries on the next edge. Values then match the reset values.

## Configuration
- IMM_GEN_GEMM_EN defined: auto-decode recognises custom-0 opcode 0001011 as GEMM format.
  - out_imm is the zero-extended inst[31:17] (15 bits).
  - out_fmt=111, out_err=0.
- IMM_GEN_GEMM_EN undefined: opcode 0001011 is treated as unsupported, giving out_imm=0, out_fmt=000, out_err=1.

## Structure
- Package imm_gen_pkg holds:
  - the enum imm_sel_e (3-bit codes above);
  - opcode localparams (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP, CUSTOM0);
  - a packed struct imm_beat_t {imm, fmt, tag, err}.
- Sub-module imm_gen_comb holds the purely combinational opcode resolve and extend. The top holds the head register, the skid register and the handshake logic.

## Test plan
- Reset, then in_sel=010, instr=0xFFF00093, out_ready=1 → one cycle later out_imm=0xFFFFFFFF, out_fmt=010, tag echoed, out_err=0.
- XLEN=64, in_sel=111, instr=0x800002B7 (LUI) → out_imm=0xFFFFFFFF80000000, out_fmt=101.
- Auto-decode of B-type 0xFE000EE3 → out_imm=0xFFFFFFFC (bit 0 = 0), out_fmt=100. Unsupported opcode 0x0000007F → out_imm=0, out_err=1.
- Back-to-back stream of 8 beats with out_ready low for 3 cycles mid-stream:
  - in_ready drops 1 cycle after the skid fills;
  - no beat is lost or duplicated;
  - tag order is preserved;
  - held outputs stay stable.
- Custom-0 instr 0xFFFE000B: with IMM_GEN_GEMM_EN → out_imm=0x7FFF, out_fmt=111. Without it → out_imm=0, out_err=1.
- rst pulsed while both entries are full → next cycle out_valid=0, in_ready=1, and all outputs are zero.
